lib_math_arbiter: RTL

//   Shares one lib_math adder instance between NUM_REQ requesters.

---
 rtl/lib_math_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lib_math_arbiter.sv
// lib_math_arbiter: round-robin front end that lets several requesters take turns
// on one shared lib_math adder. A request is granted, its operands are latched and
// driven onto the adder, the adder pipeline is waited out, and the sum is returned
// together with a one-cycle done pulse to the requester that asked for it.
module lib_math_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH:0]           result,
  output logic                     busy,
  output logic [WIDTH-1:0]         math_a,
  output logic [WIDTH-1:0]         math_b,
  input  logic [WIDTH:0]           math_sum
);

  localparam int         IDXW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] LAT_C = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q,  state_d;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]      idx_q,    idx_d;
  logic [3:0]           cnt_q,    cnt_d;
  logic [NUM_REQ-1:0]   gnt_q,    gnt_d;
  logic [NUM_REQ-1:0]   done_q,   done_d;
  logic [WIDTH:0]       result_q, result_d;
  logic [WIDTH-1:0]     math_a_q, math_a_d;
  logic [WIDTH-1:0]     math_b_q, math_b_d;

  logic                 found;
  logic [IDXW-1:0]      sel;
  int                   cand;

  // Round-robin pick: first asserted request scanning upward from rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req[IDXW'(cand)]) begin
        found = 1'b1;
        sel   = IDXW'(cand);
      end
    end
  end

  // Sequencer next state: grant and latch in IDLE, count out the adder in WAIT,
  // retire the op and advance the round-robin pointer in DONE
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    result_d = result_q;
    math_a_d = math_a_q;
    math_b_d = math_b_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          idx_d      = sel;
          math_a_d   = a_in[sel*WIDTH +: WIDTH];
          math_b_d   = b_in[sel*WIDTH +: WIDTH];
          cnt_d      = 4'd0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT_C) begin
          result_d      = math_sum;
          done_d        = '0;
          done_d[idx_q] = 1'b1;
          gnt_d         = '0;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        done_d   = '0;
        rr_ptr_d = (idx_q == IDXW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over everything, including an op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      cnt_q    <= 4'd0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      math_a_q <= '0;
      math_b_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      math_a_q <= math_a_d;
      math_b_q <= math_b_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = (state_q != S_IDLE);
  assign math_a = math_a_q;
  assign math_b = math_b_q;

endmodule
